// File: rtl/z80_bus_master.sv
// Z80-style bus master. It turns one command (mem/IO, read/write) into a
// SETUP / ACTIVE / RECOVER strobe sequence toward Blink, and it parks the bus
// in a HALT state until Blink raises an interrupt.
module z80_bus_master #(
  parameter int STROBE_CYCLES = 3
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  input  logic        halt_req,
  input  logic [7:0]  halt_i,
  output logic        halt_done,
  output logic [15:0] ca,
  output logic [7:0]  cdi,
  input  logic [7:0]  cdo,
  output logic        mrq_n,
  output logic        ior_n,
  output logic        crd_n,
  output logic        cm1_n,
  output logic        hlt_n,
  input  logic        intb_n
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_RECOVER,
    ST_HALT
  } state_t;

  // The counter runs from STROBE_CYCLES-1 down to 0, so it spans exactly STROBE_CYCLES cycles.
  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  op;        // op[1]: 1 = IO, 0 = mem; op[0]: 1 = write, 0 = read
  logic [15:0] addr;      // address held on ca outside HALT
  logic [7:0]  wdata;     // data held on cdi
  logic [3:0]  cnt;
  logic        accept;
  logic        last_active;

  assign accept      = (state == ST_IDLE) && cmd_valid;
  assign last_active = (state == ST_ACTIVE) && (cnt == 4'd0);
  assign cdi         = wdata;
  assign cm1_n       = 1'b1;

  // State register; reset abandons any bus cycle in flight.
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a pending command wins over a HALT request.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt = ST_SETUP;
        end else if (halt_req) begin
          state_nxt = ST_HALT;
        end
      end
      ST_SETUP:   state_nxt = ST_ACTIVE;
      ST_ACTIVE:  if (cnt == 4'd0) state_nxt = ST_RECOVER;
      ST_RECOVER: state_nxt = ST_IDLE;
      ST_HALT:    if (!intb_n) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Command latch and strobe counter; the HALT address is latched so ca keeps it afterwards.
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      op    <= 2'b00;
      addr  <= 16'h0000;
      wdata <= 8'h00;
      cnt   <= 4'd0;
    end else begin
      if (accept) begin
        op   <= cmd_op;
        addr <= cmd_addr;
        if (cmd_op[0]) begin
          wdata <= cmd_wdata;
        end
      end else if (state == ST_HALT) begin
        addr <= {halt_i, 8'h00};
      end
      if (state == ST_SETUP) begin
        cnt <= CNT_LOAD;
      end else if ((state == ST_ACTIVE) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Read data is sampled on the last strobe cycle, when Blink's registered data is valid.
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      rsp_rdata <= 8'h00;
      halt_done <= 1'b0;
    end else begin
      if (last_active && !op[0]) begin
        rsp_rdata <= cdo;
      end
      halt_done <= (state == ST_HALT) && !intb_n;
    end
  end

  // Strobe and handshake decode from the current state.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    mrq_n     = 1'b1;
    ior_n     = 1'b1;
    crd_n     = 1'b1;
    hlt_n     = 1'b1;
    ca        = addr;
    case (state)
      ST_IDLE: cmd_ready = rin_n;
      ST_ACTIVE: begin
        mrq_n = op[1];
        ior_n = !op[1];
        crd_n = op[0];
      end
      ST_RECOVER: rsp_valid = 1'b1;
      ST_HALT: begin
        hlt_n = 1'b0;
        ca    = {halt_i, 8'h00};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_z80_bus_master.sv
// Bench for z80_bus_master: three instances (STROBE_CYCLES = 3, 2, 15) share
// the command fields; each has its own cmd_valid and its own Blink read model.
`timescale 1ns/1ps
module tb_z80_bus_master;

  typedef struct {
    int         lat;
    int         n_mrq;
    int         n_ior;
    int         n_crd;
    logic [7:0] rdata;
    int         gap;
  } exp_t;

  logic        mck = 1'b0;
  logic        rin_n = 1'b1;
  logic [2:0]  cmd_valid_v = 3'b000;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        halt_req = 1'b0;
  logic [7:0]  halt_i = 8'h00;
  logic        intb_n = 1'b1;

  logic [2:0]  rdy_v, rsp_v, hd_v, mrq_v, ior_v, crd_v, cm1_v, hlt_v;
  logic [7:0]  rdata_v [3];
  logic [15:0] ca_v [3];
  logic [7:0]  cdi_v [3];

  int n_vec = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int          lat [3];
  int          cnt_mrq [3];
  int          cnt_ior [3];
  int          cnt_crd [3];
  int          cnt_bad [3];
  int          hi_run [3];
  int          gap_meas [3];
  bit          busy [3];
  logic [15:0] cur_addr [3];
  logic [7:0]  cur_wdata [3];
  bit          cur_wr [3];
  logic [7:0]  last_rd [3];

  always #5 mck = ~mck;

  // Blink read data: registered, valid one cycle after a read strobe falls.
  function automatic logic [7:0] mem_model(input logic [15:0] a);
    if (a == 16'hFEB2) return 8'h5A;
    return a[15:8] ^ a[7:0];
  endfunction

  function automatic int sc(input int i);
    if (i == 0) return 3;
    if (i == 1) return 2;
    return 15;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] cdo_m = 8'hEE;
    always @(posedge mck) begin
      if (!crd_v[g] && (!mrq_v[g] || !ior_v[g])) cdo_m <= mem_model(ca_v[g]);
      else cdo_m <= 8'hEE;
    end
    z80_bus_master #(.STROBE_CYCLES(g == 0 ? 3 : (g == 1 ? 2 : 15))) u_dut (
      .mck(mck), .rin_n(rin_n),
      .cmd_valid(cmd_valid_v[g]), .cmd_ready(rdy_v[g]),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_v[g]), .rsp_rdata(rdata_v[g]),
      .halt_req(halt_req), .halt_i(halt_i), .halt_done(hd_v[g]),
      .ca(ca_v[g]), .cdi(cdi_v[g]), .cdo(cdo_m),
      .mrq_n(mrq_v[g]), .ior_n(ior_v[g]), .crd_n(crd_v[g]),
      .cm1_n(cm1_v[g]), .hlt_n(hlt_v[g]), .intb_n(intb_n)
    );
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int i, output exp_t e);
    case (i)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic qclear(input int i);
    case (i)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic mon_one(input int i);
    exp_t e;
    bit   lo;
    if (!rin_n) begin
      busy[i] = 0;
      hi_run[i] = 0;
      qclear(i);
    end else begin
      lo = !mrq_v[i] || !ior_v[i];
      if (busy[i]) begin
        lat[i]++;
        if (!mrq_v[i]) cnt_mrq[i]++;
        if (!ior_v[i]) cnt_ior[i]++;
        if (!crd_v[i]) cnt_crd[i]++;
        if (lo && (ca_v[i] !== cur_addr[i] || (cur_wr[i] && cdi_v[i] !== cur_wdata[i]) ||
                   (!mrq_v[i] && !ior_v[i])))
          cnt_bad[i]++;
      end
      if (lo) begin
        if (hi_run[i] != 0) gap_meas[i] = hi_run[i];
        hi_run[i] = 0;
      end else begin
        hi_run[i]++;
      end
      if (rsp_v[i]) begin
        if (qsize(i) == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_rsp[%0d]: rsp_valid=1, expected 0", i);
        end else begin
          qpop(i, e);
          chk("latency", i, lat[i], e.lat);
          chk("mrq_cycles", i, cnt_mrq[i], e.n_mrq);
          chk("ior_cycles", i, cnt_ior[i], e.n_ior);
          chk("crd_cycles", i, cnt_crd[i], e.n_crd);
          chk("bus_errors", i, cnt_bad[i], 0);
          chk("rsp_rdata", i, rdata_v[i], e.rdata);
          if (e.gap >= 0) chk("strobe_gap", i, gap_meas[i], e.gap);
        end
        busy[i] = 0;
      end
      if (cmd_valid_v[i] && rdy_v[i]) begin
        busy[i] = 1;
        lat[i] = 0;
        cnt_mrq[i] = 0;
        cnt_ior[i] = 0;
        cnt_crd[i] = 0;
        cnt_bad[i] = 0;
        cur_addr[i] = cmd_addr;
        cur_wdata[i] = cmd_wdata;
        cur_wr[i] = cmd_op[0];
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge mck);
      for (int i = 0; i < 3; i++) mon_one(i);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [2:0] mask, input logic [1:0] op, input logic [15:0] addr,
                       input logic [7:0] wd, input logic [7:0] rd, input int gap);
    exp_t e;
    int   t;
    t = 0;
    while (((rdy_v & mask) != mask) && t < 100) begin
      @(posedge mck); #1;
      t++;
    end
    if ((rdy_v & mask) != mask) begin
      n_vec++;
      n_fail++;
      $display("FAIL issue_timeout: ready=%b, expected %b", rdy_v & mask, mask);
    end else begin
      cmd_op = op;
      cmd_addr = addr;
      cmd_wdata = wd;
      cmd_valid_v = mask;
      for (int i = 0; i < 3; i++) begin
        if (mask[i]) begin
          e.lat = 2 + sc(i);
          e.n_mrq = op[1] ? 0 : sc(i);
          e.n_ior = op[1] ? sc(i) : 0;
          e.n_crd = op[0] ? 0 : sc(i);
          if (!op[0]) last_rd[i] = rd;
          e.rdata = last_rd[i];
          e.gap = gap;
          qpush(i, e);
        end
      end
      @(posedge mck); #1;
      cmd_valid_v = 3'b000;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (((q0.size() + q1.size() + q2.size()) != 0 || rdy_v != 3'b111) && t < 200) begin
      @(posedge mck); #1;
      t++;
    end
    if ((q0.size() + q1.size() + q2.size()) != 0 || rdy_v != 3'b111) begin
      n_vec++;
      n_fail++;
      $display("FAIL idle_timeout: pending=%0d ready=%b, expected 0 and 111",
               q0.size() + q1.size() + q2.size(), rdy_v);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      last_rd[i] = 8'h00;
      busy[i] = 0;
      hi_run[i] = 0;
      gap_meas[i] = 0;
    end
    fork
      monitor();
    join_none

    // Asynchronous reset before any clock edge.
    #1 rin_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", i, rdy_v[i], 0);
      chk("rst_rsp_valid", i, rsp_v[i], 0);
      chk("rst_halt_done", i, hd_v[i], 0);
      chk("rst_ca", i, ca_v[i], 16'h0000);
      chk("rst_cdi", i, cdi_v[i], 8'h00);
      chk("rst_rdata", i, rdata_v[i], 8'h00);
      chk("rst_strobes", i, {mrq_v[i], ior_v[i], crd_v[i], cm1_v[i], hlt_v[i]}, 5'h1F);
    end
    @(posedge mck); @(posedge mck); #1;
    rin_n = 1'b1;
    @(posedge mck); #1;
    chk("ready_after_reset", 0, rdy_v, 3'b111);

    // IO write 00D1 <- 21 on all three instances.
    issue(3'b111, 2'b11, 16'h00D1, 8'h21, 8'h00, -1);
    for (int i = 0; i < 3; i++) begin
      chk("setup_ca", i, ca_v[i], 16'h00D1);
      chk("setup_cdi", i, cdi_v[i], 8'h21);
      chk("setup_strobes", i, {mrq_v[i], ior_v[i], crd_v[i]}, 3'b111);
    end
    wait_idle();

    // IO read FEB2 -> 5A.
    issue(3'b111, 2'b10, 16'hFEB2, 8'h00, 8'h5A, -1);
    wait_idle();

    // Mem read 1234 -> 26 then mem write back-to-back; write leaves rsp_rdata at 26.
    issue(3'b001, 2'b00, 16'h1234, 8'h00, 8'h26, -1);
    issue(3'b001, 2'b01, 16'h1234, 8'h99, 8'h00, 3);
    wait_idle();

    // Boundary instances: mem read 0F3C -> 33.
    issue(3'b110, 2'b00, 16'h0F3C, 8'h00, 8'h33, -1);
    wait_idle();

    // HALT entry with live I-register tracking.
    halt_i = 8'h3F;
    halt_req = 1'b1;
    @(posedge mck); #1;
    halt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("halt_hlt_n", i, hlt_v[i], 0);
      chk("halt_ca", i, ca_v[i], 16'h3F00);
      chk("halt_strobes", i, {mrq_v[i], ior_v[i], crd_v[i]}, 3'b111);
      chk("halt_ready", i, rdy_v[i], 0);
    end
    halt_i = 8'hC4;
    #1;
    chk("halt_ca_live", 0, ca_v[0], 16'hC400);
    halt_i = 8'h3F;
    repeat (10) @(posedge mck);
    #1;
    chk("halt_held", 0, hlt_v, 3'b000);
    intb_n = 1'b0;
    @(posedge mck); #1;
    intb_n = 1'b1;
    chk("halt_exit_hlt_n", 0, hlt_v, 3'b111);
    chk("halt_done_pulse", 0, hd_v, 3'b111);
    chk("halt_exit_ready", 0, rdy_v, 3'b111);
    @(posedge mck); #1;
    chk("halt_done_clear", 0, hd_v, 3'b000);

    // HALT with intb_n already low still lasts one cycle.
    intb_n = 1'b0;
    halt_req = 1'b1;
    @(posedge mck); #1;
    halt_req = 1'b0;
    chk("halt_min_entry", 0, hlt_v, 3'b000);
    @(posedge mck); #1;
    intb_n = 1'b1;
    chk("halt_min_exit", 0, hlt_v, 3'b111);
    chk("halt_min_done", 0, hd_v, 3'b111);
    @(posedge mck); #1;

    // Command and HALT request together: the command runs, intb_n is ignored meanwhile.
    halt_req = 1'b1;
    intb_n = 1'b0;
    issue(3'b111, 2'b01, 16'h4000, 8'h77, 8'h00, -1);
    halt_req = 1'b0;
    chk("cmd_over_halt", 0, hlt_v, 3'b111);
    wait_idle();
    intb_n = 1'b1;
    chk("no_halt_done", 0, hd_v, 3'b000);

    // Reset during the second strobe cycle of a mem read.
    issue(3'b001, 2'b00, 16'h2468, 8'h00, 8'h4C, -1);
    @(posedge mck); #1;
    @(posedge mck); #1;
    chk("active2_mrq", 0, mrq_v[0], 0);
    rin_n = 1'b0;
    #1;
    chk("abort_strobes", 0, {mrq_v[0], ior_v[0], crd_v[0]}, 3'b111);
    chk("abort_rsp_valid", 0, rsp_v[0], 0);
    chk("abort_ready", 0, rdy_v[0], 0);
    chk("abort_ca", 0, ca_v[0], 16'h0000);
    chk("abort_rdata", 0, rdata_v[0], 8'h00);
    for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;
    @(posedge mck); @(posedge mck); #1;
    rin_n = 1'b1;
    @(posedge mck); #1;
    chk("ready_after_abort", 0, rdy_v, 3'b111);
    repeat (20) @(posedge mck);
    #1;

    // Normal traffic after the abort.
    issue(3'b111, 2'b10, 16'hFEB2, 8'h00, 8'h5A, -1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
